// File: rtl/jtkunio_pkg.sv
// Shared types and widths for the jtkunio scroll ROM request path.
package jtkunio_pkg;

    localparam int unsigned SDRAM_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL
    } state_e;

endpackage

// File: rtl/jtkunio_romcache2.sv
// Two-entry tag/data store with combinational hit detect and 1-bit LRU victim pointer.
module jtkunio_romcache2 #(
    parameter int unsigned TW = 16,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] tag_in,
    output logic          hit_c,
    output logic [DW-1:0] hit_data_c,
    input  logic          fill_en,
    input  logic [TW-1:0] fill_tag,
    input  logic [DW-1:0] fill_data
);

    logic [1:0]         valid_q, valid_d;
    logic [1:0][TW-1:0] tag_q,   tag_d;
    logic [1:0][DW-1:0] data_q,  data_d;
    logic               lru_q,   lru_d;
    logic               hit0_c,  hit1_c;

    always_comb begin
        hit0_c     = valid_q[0] && (tag_q[0] == tag_in);
        hit1_c     = valid_q[1] && (tag_q[1] == tag_in);
        hit_c      = hit0_c || hit1_c;
        hit_data_c = hit1_c ? data_q[1] : data_q[0];
    end

    // A fill overwrites the victim and makes it most recent; otherwise a hit retargets the victim.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        lru_d   = lru_q;
        if (fill_en) begin
            valid_d[lru_q] = 1'b1;
            tag_d[lru_q]   = fill_tag;
            data_d[lru_q]  = fill_data;
            lru_d          = ~lru_q;
        end else if (hit0_c) begin
            lru_d = 1'b1;
        end else if (hit1_c) begin
            lru_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            lru_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            lru_q   <= lru_d;
        end
    end

endmodule

// File: rtl/jtkunio_scr_romrq.sv
// Scroll-layer ROM responder: serves hits from a two-entry cache, turns misses into SDRAM reads.
module jtkunio_scr_romrq
    import jtkunio_pkg::*;
#(
    parameter int unsigned    AW     = 17,
    parameter int unsigned    DW     = 32,
    parameter int unsigned    SDW    = SDRAM_AW,
    parameter logic [SDW-1:0] OFFSET = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rom_cs,
    input  logic [AW-1:0]  rom_addr,
    output logic [DW-1:0]  rom_data,
    output logic           rom_ok,
    output logic           sdram_req,
    output logic [SDW-1:0] sdram_addr,
    input  logic           sdram_ack,
    input  logic           sdram_dok,
    input  logic [DW-1:0]  sdram_data
);

    localparam int unsigned TW = AW - 1;

    state_e         state_q,      state_d;
    logic [TW-1:0]  req_tag_q,    req_tag_d;
    logic           sdram_req_q,  sdram_req_d;
    logic [SDW-1:0] sdram_addr_q, sdram_addr_d;
    logic           rom_ok_q,     rom_ok_d;
    logic [DW-1:0]  rom_data_q,   rom_data_d;

    logic [TW-1:0]  tag_c;
    logic           hit_c;
    logic [DW-1:0]  hit_data_c;
    logic           fill_en_c;
    logic           addr_lsb_unused;

    // Word pairs share one cache line, so the low address bit never reaches the tag.
    assign tag_c           = rom_addr[AW-1:1];
    assign addr_lsb_unused = rom_addr[0];

    jtkunio_romcache2 #(
        .TW (TW),
        .DW (DW)
    ) u_cache (
        .clk        (clk),
        .rst_n      (rst_n),
        .tag_in     (tag_c),
        .hit_c      (hit_c),
        .hit_data_c (hit_data_c),
        .fill_en    (fill_en_c),
        .fill_tag   (req_tag_q),
        .fill_data  (sdram_data)
    );

    // Next-state, request and output logic; hits are registered in every state.
    always_comb begin
        state_d      = state_q;
        req_tag_d    = req_tag_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        fill_en_c    = 1'b0;
        rom_ok_d     = hit_c;
        rom_data_d   = hit_c ? hit_data_c : rom_data_q;

        case (state_q)
            ST_IDLE: begin
                if (!hit_c && rom_cs) begin
                    req_tag_d    = tag_c;
                    sdram_addr_d = SDW'({tag_c, 1'b0}) + OFFSET;
                    sdram_req_d  = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack arriving together with its data is taken as ack followed by data.
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    if (sdram_dok) begin
                        fill_en_c = 1'b1;
                        state_d   = ST_FILL;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (sdram_dok) begin
                    fill_en_c = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_tag_q    <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            rom_ok_q     <= 1'b0;
            rom_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            rom_ok_q     <= rom_ok_d;
            rom_data_q   <= rom_data_d;
        end
    end

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign rom_ok     = rom_ok_q;
    assign rom_data   = rom_data_q;

endmodule

// File: tb/tb_jtkunio_scr_romrq.sv
// Directed bench for jtkunio_scr_romrq with a queue-based scoreboard of SDRAM addresses and read data.
module tb_jtkunio_scr_romrq;

    localparam int unsigned AW  = 17;
    localparam int unsigned DW  = 32;
    localparam int unsigned SDW = 22;
    localparam logic [SDW-1:0] B_OFFSET = 22'h3FFFF0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;

    logic           rom_cs, sdram_ack, sdram_dok;
    logic [AW-1:0]  rom_addr;
    logic [DW-1:0]  rom_data, sdram_data;
    logic           rom_ok, sdram_req;
    logic [SDW-1:0] sdram_addr;

    logic           b_rom_cs, b_sdram_ack, b_sdram_dok;
    logic [AW-1:0]  b_rom_addr;
    logic [DW-1:0]  b_rom_data, b_sdram_data;
    logic           b_rom_ok, b_sdram_req;
    logic [SDW-1:0] b_sdram_addr;

    int vectors = 0;
    int miscompares = 0;

    logic [SDW-1:0] exp_addr_q[$];
    logic [DW-1:0]  exp_data_q[$];

    always #5 clk = ~clk;

    jtkunio_scr_romrq #(.AW(AW), .DW(DW), .SDW(SDW), .OFFSET(22'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok), .sdram_req(sdram_req),
        .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_dok(sdram_dok),
        .sdram_data(sdram_data)
    );

    jtkunio_scr_romrq #(.AW(AW), .DW(DW), .SDW(SDW), .OFFSET(B_OFFSET)) dut_b (
        .clk(clk), .rst_n(rst_n), .rom_cs(b_rom_cs), .rom_addr(b_rom_addr),
        .rom_data(b_rom_data), .rom_ok(b_rom_ok), .sdram_req(b_sdram_req),
        .sdram_addr(b_sdram_addr), .sdram_ack(b_sdram_ack), .sdram_dok(b_sdram_dok),
        .sdram_data(b_sdram_data)
    );

    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
        return {8'hA5, 7'h00, a[AW-1:1], 1'b0};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (sdram_req) break;
            step();
        end
        chk(tag, 64'(sdram_req), 64'd1);
    endtask

    // Full miss on dut_a: ack two cycles after the request, data two cycles after the ack.
    task automatic fetch(input logic [AW-1:0] addr);
        logic [SDW-1:0] ea;
        logic [DW-1:0]  ed;
        rom_addr = addr;
        exp_addr_q.push_back(SDW'({addr[AW-1:1], 1'b0}));
        exp_data_q.push_back(dat(addr));
        wait_req("req_rise");
        ea = exp_addr_q.pop_front();
        chk("sdram_addr", 64'(sdram_addr), 64'(ea));
        step(2);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        chk("req_drop", 64'(sdram_req), 64'd0);
        step(2);
        sdram_dok  = 1'b1;
        sdram_data = dat(addr);
        step();
        sdram_dok  = 1'b0;
        sdram_data = 32'hDEAD_BEEF;
        chk("ok_latency", 64'(rom_ok), 64'd0);
        step();
        ed = exp_data_q.pop_front();
        chk("rom_ok", 64'(rom_ok), 64'd1);
        chk("rom_data", 64'(rom_data), 64'(ed));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0]  a;
        logic [SDW-1:0] ea;
        logic [DW-1:0]  ed;

        rom_cs = 1'b0; rom_addr = '0; sdram_ack = 1'b0; sdram_dok = 1'b0; sdram_data = '0;
        b_rom_cs = 1'b0; b_rom_addr = '0; b_sdram_ack = 1'b0; b_sdram_dok = 1'b0; b_sdram_data = '0;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);

        // Reset state
        chk("rst_rom_ok", 64'(rom_ok), 64'd0);
        chk("rst_rom_data", 64'(rom_data), 64'd0);
        chk("rst_sdram_req", 64'(sdram_req), 64'd0);
        chk("rst_sdram_addr", 64'(sdram_addr), 64'd0);
        chk("rst_b_req", 64'(b_sdram_req), 64'd0);

        // Cold misses, then alternating hits (bit 0 ignored on one step)
        rom_cs = 1'b1;
        fetch(17'h0400);
        fetch(17'h0402);
        for (int i = 0; i < 8; i++) begin
            a = (i % 2 == 1) ? 17'h0402 : 17'h0400;
            if (i == 4) a = 17'h0401;
            rom_addr = a;
            step();
            chk("alt_ok", 64'(rom_ok), 64'd1);
            chk("alt_data", 64'(rom_data), 64'(dat(a)));
            chk("alt_no_req", 64'(sdram_req), 64'd0);
        end

        // LRU: touch A, miss on C evicts B
        rom_addr = 17'h0400;
        step(2);
        chk("lru_touch_a", 64'(rom_ok), 64'd1);
        fetch(17'h0800);
        rom_addr = 17'h0400;
        step();
        chk("lru_a_ok", 64'(rom_ok), 64'd1);
        chk("lru_a_data", 64'(rom_data), 64'(dat(17'h0400)));
        chk("lru_a_no_req", 64'(sdram_req), 64'd0);
        fetch(17'h0402);

        // Address change during WAIT, rom_cs dropped mid-transfer
        rom_addr = 17'h1000;
        exp_addr_q.push_back(22'h001000);
        wait_req("mid_req");
        ea = exp_addr_q.pop_front();
        chk("mid_addr", 64'(sdram_addr), 64'(ea));
        rom_cs = 1'b0;
        step(2);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        rom_addr = 17'h2000;
        rom_cs = 1'b1;
        step();
        sdram_dok = 1'b1;
        sdram_data = dat(17'h1000);
        step();
        sdram_dok = 1'b0;
        sdram_data = 32'hDEAD_BEEF;
        chk("mid_no_ok_fill", 64'(rom_ok), 64'd0);
        step();
        chk("mid_no_ok_idle", 64'(rom_ok), 64'd0);
        fetch(17'h2000);
        rom_addr = 17'h1000;
        step();
        chk("mid_old_ok", 64'(rom_ok), 64'd1);
        chk("mid_old_data", 64'(rom_data), 64'(dat(17'h1000)));

        // Same-cycle ack+dok with wrapping offset on dut_b
        b_rom_addr = 17'h0020;
        b_rom_cs = 1'b1;
        exp_addr_q.push_back(B_OFFSET + SDW'({b_rom_addr[AW-1:1], 1'b0}));
        exp_data_q.push_back(dat(17'h0020));
        for (int i = 0; i < 16; i++) begin
            if (b_sdram_req) break;
            step();
        end
        chk("wrap_req", 64'(b_sdram_req), 64'd1);
        ea = exp_addr_q.pop_front();
        chk("wrap_addr", 64'(b_sdram_addr), 64'(ea));
        chk("wrap_addr_const", 64'(b_sdram_addr), 64'h10);
        step();
        b_sdram_ack = 1'b1;
        b_sdram_dok = 1'b1;
        b_sdram_data = dat(17'h0020);
        step();
        b_sdram_ack = 1'b0;
        b_sdram_dok = 1'b0;
        b_sdram_data = 32'hDEAD_BEEF;
        chk("wrap_req_drop", 64'(b_sdram_req), 64'd0);
        chk("wrap_ok_latency", 64'(b_rom_ok), 64'd0);
        step();
        ed = exp_data_q.pop_front();
        chk("wrap_ok", 64'(b_rom_ok), 64'd1);
        chk("wrap_data", 64'(b_rom_data), 64'(ed));

        // Reset during WAIT, then a stray dok
        rom_addr = 17'h3000;
        wait_req("rstw_req");
        chk("rstw_addr", 64'(sdram_addr), 64'h3000);
        step();
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        rom_cs = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rstw_async_req", 64'(sdram_req), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        sdram_dok = 1'b1;
        sdram_data = dat(17'h3000);
        step();
        sdram_dok = 1'b0;
        step();
        chk("rstw_rom_ok", 64'(rom_ok), 64'd0);
        chk("rstw_rom_data", 64'(rom_data), 64'd0);
        chk("rstw_req", 64'(sdram_req), 64'd0);
        chk("rstw_sdram_addr", 64'(sdram_addr), 64'd0);
        rom_addr = 17'h0400;
        step(2);
        chk("rstw_inval_a", 64'(rom_ok), 64'd0);
        chk("rstw_cs_idle", 64'(sdram_req), 64'd0);
        rom_addr = 17'h3000;
        step();
        chk("rstw_stray_ignored", 64'(rom_ok), 64'd0);
        rom_cs = 1'b1;
        fetch(17'h3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
